// File: rtl/audio_pkg.sv
// Shared audio-path types and defaults used by the filter and I2S stages.
package audio_pkg;

    localparam int unsigned AUDIO_SAMPLE_W   = 16;
    localparam int unsigned I2S_SLOT_W_DEF   = 32;
    localparam int unsigned I2S_BCLK_DIV_DEF = 12;

    typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;

    // Counter width for a range of v values, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock generator: divides Clk down to BCLK and flags each toggle.
// rise_tick/fall_tick are high in the Clk cycle whose edge toggles bclk.
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = I2S_BCLK_DIV_DEF
) (
    input  logic Clk,
    input  logic Reset,
    output logic bclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned         CNT_W  = clog2_min1(BCLK_DIV);
    localparam logic [CNT_W-1:0]    CNT_TC = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             term_c;

    // Terminal count marks the edge at which bclk toggles
    always_comb begin
        term_c    = (div_cnt == CNT_TC);
        rise_tick = term_c & ~bclk;
        fall_tick = term_c & bclk;
    end

    // Half-period divider and bit-clock register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (term_c) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the codec DAC: one mono sample per frame, sent on both
// channels, MSB first with the standard one-bit delay after LRCLK changes.
// Build option I2S_UNDERRUN_HOLD_EN: on underrun retransmit the previous
// sample instead of silence.
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = I2S_BCLK_DIV_DEF,
    parameter int unsigned SLOT_W   = I2S_SLOT_W_DEF,
    parameter int unsigned SAMPLE_W = AUDIO_SAMPLE_W
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       dacdat,
    output logic                       frame_start,
    output logic                       underrun
);

    localparam int unsigned        BIT_W    = $clog2(2 * SLOT_W);
    localparam int unsigned        IDX_W    = clog2_min1(SAMPLE_W);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0]   SLOT_K   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0]   DATA_END = BIT_W'(SAMPLE_W);

    logic                rise_tick;
    logic                fall_tick;
    logic                unused_rise;

    logic [BIT_W-1:0]    bit_cnt;
    logic                buf_full;
    logic [SAMPLE_W-1:0] buf_data;
    logic [SAMPLE_W-1:0] data;

    logic                in_right_c;
    logic [BIT_W-1:0]    pos_c;
    logic [IDX_W-1:0]    bit_idx_c;
    logic                ser_bit_c;
    logic                accept_c;
    logic                load_c;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .Clk       (Clk),
        .Reset     (Reset),
        .bclk      (bclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Outputs only move on falling BCLK, so the rise is not needed here
    assign unused_rise = rise_tick;

    // Slot position and the serial bit to launch at the next fall tick
    always_comb begin
        in_right_c = (bit_cnt >= SLOT_K);
        pos_c      = in_right_c ? (bit_cnt - SLOT_K) : bit_cnt;
        bit_idx_c  = IDX_W'(SAMPLE_W - 32'(pos_c));
        ser_bit_c  = 1'b0;
        if ((pos_c != '0) && (pos_c <= DATA_END)) begin
            ser_bit_c = data[bit_idx_c];
        end
    end

    // Handshake: buffer accepts only when empty and out of reset
    always_comb begin
        sample_ready = ~buf_full & ~Reset;
        accept_c     = sample_valid & sample_ready;
        load_c       = fall_tick & (bit_cnt == '0);
    end

    // Bit counter, one-entry buffer, frame data and serial output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bit_cnt     <= '0;
            buf_full    <= 1'b0;
            buf_data    <= '0;
            data        <= '0;
            lrclk       <= 1'b0;
            dacdat      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (accept_c) begin
                buf_full <= 1'b1;
                buf_data <= sample_in;
            end

            if (fall_tick) begin
                lrclk   <= in_right_c;
                dacdat  <= ser_bit_c;
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : (bit_cnt + BIT_W'(1));
            end

            // An accept in this cycle cannot coincide with consuming a full buffer
            if (load_c) begin
                frame_start <= 1'b1;
                if (buf_full) begin
                    data     <= buf_data;
                    buf_full <= 1'b0;
                end else begin
                    underrun <= 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
                    data     <= data;
`else
                    data     <= '0;
`endif
                end
            end
        end
    end

endmodule
